// File: rtl/hamming_pkg.sv
// Shared constants, codeword layout and error classification for the SECDED
// extended Hamming(15,11) decoder.
package hamming_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned MSG_W  = 11;
  localparam int unsigned SYN_W  = 4;

  // Codeword positions carrying message bits, message bit 0 first.
  localparam logic [3:0] DATA_POS [MSG_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Syndrome bit b covers every position whose index has bit b set.
  localparam logic [CODE_W-1:0] PAR_MASK [SYN_W] = '{
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00
  };

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_e;

  // Odd overall parity means exactly one flipped bit, located by s (0 = bit 0).
  function automatic err_e classify(input logic [SYN_W-1:0] s, input logic p);
    if (p)
      return ERR_SINGLE;
    else if (s != '0)
      return ERR_DOUBLE;
    else
      return ERR_NONE;
  endfunction

  function automatic logic [MSG_W-1:0] extract_msg(input logic [CODE_W-1:0] c);
    logic [MSG_W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MSG_W; k++)
      m[k[3:0]] = c[DATA_POS[k[3:0]]];
    return m;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 16-bit extended
// Hamming codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  s,
  output logic              p
);

  always_comb begin
    s = '0;
    for (int unsigned b = 0; b < SYN_W; b++)
      s[b[1:0]] = ^(code & PAR_MASK[b[1:0]]);
    p = ^code;
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage SECDED decoder with valid/ready on both sides and saturating
// error counters. Define HAMMING_DEC_SYNDROME_EN to expose out_syndrome.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_msg,
  output logic              out_corrected,
  output logic              out_uncorrectable,
`ifdef HAMMING_DEC_SYNDROME_EN
  output logic [4:0]        out_syndrome,
`endif
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              advance;
  logic [SYN_W-1:0]  syn;
  logic              par;

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_p;

  err_e              err;
  logic [CODE_W-1:0] fixed;
  logic              xfer;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign xfer     = out_valid & out_ready;

  hamming_syndrome u_syndrome (
    .code (in_code),
    .s    (syn),
    .p    (par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_p     <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= syn;
        s1_p    <= par;
      end
    end
  end

  always_comb begin
    err   = classify(s1_syn, s1_p);
    fixed = s1_code;
    if (err == ERR_SINGLE)
      fixed[s1_syn] = ~s1_code[s1_syn];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_msg           <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
`ifdef HAMMING_DEC_SYNDROME_EN
      out_syndrome      <= '0;
`endif
    end else if (advance) begin
      out_valid <= s1_valid;
      // Bubbles leave the last delivered payload in place; only valid words load.
      if (s1_valid) begin
        out_msg           <= extract_msg(fixed);
        out_corrected     <= (err == ERR_SINGLE);
        out_uncorrectable <= (err == ERR_DOUBLE);
`ifdef HAMMING_DEC_SYNDROME_EN
        out_syndrome      <= {s1_p, s1_syn};
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (out_corrected && corr_cnt != '1)
        corr_cnt <= corr_cnt + 1'b1;
      if (out_uncorrectable && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: default-width instance plus a CNT_W=2
// instance driven by the same stimulus to exercise counter saturation.
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_corrected, out_uncorrectable;
  logic [10:0] out_msg;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        b_in_ready, b_out_valid, b_out_corrected, b_out_uncorrectable;
  logic [10:0] b_out_msg;
  logic [1:0]  b_corr_cnt, b_uncorr_cnt;
`ifdef HAMMING_DEC_SYNDROME_EN
  logic [4:0]  out_syndrome, b_out_syndrome;
`endif

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable),
`ifdef HAMMING_DEC_SYNDROME_EN
    .out_syndrome(out_syndrome),
`endif
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_msg(b_out_msg), .out_corrected(b_out_corrected),
    .out_uncorrectable(b_out_uncorrectable),
`ifdef HAMMING_DEC_SYNDROME_EN
    .out_syndrome(b_out_syndrome),
`endif
    .cnt_clr(cnt_clr), .corr_cnt(b_corr_cnt), .uncorr_cnt(b_uncorr_cnt)
  );

  typedef struct {
    logic [10:0] msg;
    logic        corr;
    logic        uncorr;
    logic [4:0]  syn;
    bit          chk_lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int unsigned m_corr = 0, m_uncorr = 0, m2_corr = 0, m2_uncorr = 0;
  bit          x_corr = 0, x_uncorr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counter model: applies the flags of the word popped at the preceding negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_corr = 0; m_uncorr = 0; m2_corr = 0; m2_uncorr = 0;
    end else if (cnt_clr) begin
      m_corr = 0; m_uncorr = 0; m2_corr = 0; m2_uncorr = 0;
    end else begin
      if (x_corr) begin
        if (m_corr < 65535) m_corr++;
        if (m2_corr < 3) m2_corr++;
      end
      if (x_uncorr) begin
        if (m_uncorr < 65535) m_uncorr++;
        if (m2_uncorr < 3) m2_uncorr++;
      end
    end
  end

  // Monitor: counters every cycle, payload on transfer, stability under stall.
  always @(negedge clk) begin
    exp_t e;
    check("corr_cnt", 32'(corr_cnt), m_corr);
    check("uncorr_cnt", 32'(uncorr_cnt), m_uncorr);
    check("corr_cnt_w2", 32'(b_corr_cnt), m2_corr);
    check("uncorr_cnt_w2", 32'(b_uncorr_cnt), m2_uncorr);
    x_corr = 0;
    x_uncorr = 0;
    if (out_valid && sbq.size() == 0) begin
      check("unexpected_out_valid", 32'(out_valid), 32'd0);
    end else if (out_valid && out_ready) begin
      e = sbq.pop_front();
      check("out_msg", 32'(out_msg), 32'(e.msg));
      check("out_corrected", 32'(out_corrected), 32'(e.corr));
      check("out_uncorrectable", 32'(out_uncorrectable), 32'(e.uncorr));
      check("out_msg_w2", 32'(b_out_msg), 32'(e.msg));
`ifdef HAMMING_DEC_SYNDROME_EN
      check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
`endif
      if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'd1);
      x_corr = e.corr;
      x_uncorr = e.uncorr;
    end else if (out_valid && !out_ready) begin
      check("stall_msg", 32'(out_msg), 32'(sbq[0].msg));
      check("stall_corrected", 32'(out_corrected), 32'(sbq[0].corr));
`ifdef HAMMING_DEC_SYNDROME_EN
      check("stall_syndrome", 32'(out_syndrome), 32'(sbq[0].syn));
`endif
    end
  end

  task automatic send(input logic [15:0] code, input logic [10:0] msg, input logic c,
                      input logic u, input logic [4:0] syn, input bit lat);
    int t;
    exp_t e;
    in_valid = 1'b1;
    in_code  = code;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    e.msg = msg; e.corr = c; e.uncorr = u; e.syn = syn; e.chk_lat = lat; e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    int t;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [3:0] ib;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_msg", 32'(out_msg), 32'd0);
    check("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean words
    send(16'h0000, 11'h000, 0, 0, 5'h00, 1);
    send(16'hFFFF, 11'h7FF, 0, 0, 5'h00, 1);
    send(16'h000F, 11'h001, 0, 0, 5'h00, 1);
    drain();

    // Single and double errors
    send(16'hFFDF, 11'h7FF, 1, 0, 5'h15, 1);
    drain();
    check("corr_cnt_after_first", 32'(corr_cnt), 32'd1);
    send(16'h0001, 11'h000, 1, 0, 5'h10, 1);
    send(16'hFFD7, 11'h7FC, 0, 1, 5'h06, 1);
    drain();
    check("uncorr_cnt_after_double", 32'(uncorr_cnt), 32'd1);

    for (int i = 0; i < 16; i++) begin
      ib = 4'(i);
      send(16'h000F ^ (16'h0001 << i), 11'h001, 1, 0, {1'b1, ib}, 1);
    end
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(16'h0000, 11'h000, 0, 0, 5'h00, 0);
    send(16'hFFFF, 11'h7FF, 0, 0, 5'h00, 0);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      begin
        send(16'h000F, 11'h001, 0, 0, 5'h00, 0);
        send(16'hFFDF, 11'h7FF, 1, 0, 5'h15, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation on the CNT_W=2 instance
    pulse_clr();
    repeat (5) send(16'hFFDF, 11'h7FF, 1, 0, 5'h15, 1);
    drain();
    @(negedge clk);
    check("sat_corr_cnt", 32'(corr_cnt), 32'd5);
    check("sat_corr_cnt_w2", 32'(b_corr_cnt), 32'd3);

    // Clear coinciding with a corrected transfer
    @(posedge clk);
    #1;
    send(16'h0001, 11'h000, 1, 0, 5'h10, 1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("clr_wait_out_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    check("clr_corr_cnt_w2", 32'(b_corr_cnt), 32'd0);

    // Reset with both stages full
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'hFFFF, 11'h7FF, 0, 0, 5'h00, 0);
    send(16'h000F, 11'h001, 0, 0, 5'h00, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'h000F, 11'h001, 0, 0, 5'h00, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
